fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter, which is a word index. Drives the memory's word address and captures the 32-bit word the memory returns combinationally in the same cycle.
- Presents the word to decode through a registered valid/ready output stage.
- Handles stalls, branch/jump redirects with flush, and halting on EBREAK.

Parameters:
- ADDR_W, 6, width of the word-index PC and memory address.
- MEM_DEPTH, 48, number of 32-bit words in instruction memory. Valid indices are 0..MEM_DEPTH-1.
- RESET_PC, 0, word index loaded into the PC on reset.
- HALT_INSTR, 32'h00100073, encoding that halts fetch (EBREAK).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- imem_addr  output  ADDR_W  word address to instruction memory; equals the PC register.
- imem_data  input  32  instruction word from memory; valid in the same cycle as imem_addr.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  ADDR_W  word index of the redirect destination.
- if_valid  output  1  if_instr and if_pc hold a valid fetched instruction.
- if_ready  input  1  decode accepts the instruction this cycle.
- if_instr  output  32  registered instruction word.
- if_pc  output  ADDR_W  word index the instruction was fetched from.
- halted  output  1  fetch is stopped in the HALT state.

Behaviour:
- Reset (asynchronous, rst=1):
  - pc=RESET_PC, state=START.
  - if_valid=0, if_instr=0, if_pc=0, halted=0.
- Handshake:
  - A transfer occurs on a cycle with if_valid=1 and if_ready=1.
  - The output register may load when it is free: if_valid=0, or a transfer occurs this cycle.
  - While if_valid=1 and if_ready=0, if_instr, if_pc and pc hold stable. This is a stall.
- States:
  - START: first cycle after reset release. No capture. Next state is FETCH. Lets imem_addr settle.
  - FETCH, when free and no redirect:
    - if_instr<=imem_data, if_pc<=pc, if_valid<=1.
    - pc<=next_seq(pc).
    - If imem_data==HALT_INSTR, the next state is HALT and pc holds instead of advancing.
  - FETCH, when not free: hold everything.
  - HALT:
    - halted=1. pc holds and no new capture occurs.
    - The captured HALT_INSTR stays presented until it is consumed; after that, if_valid=0.
- next_seq(pc) = pc+1, wrapping to 0 when pc==MEM_DEPTH-1.
- Redirect (redirect_valid=1) has priority over capture, stall and HALT, in any state except START:
  - pc<=redirect_target, or 0 if redirect_target>=MEM_DEPTH.
  - if_valid<=0 (flush, even if stalled); state<=FETCH; halted<=0.
  - The first instruction from the target is presented one cycle later. Redirect-to-valid latency is 2 cycles.
- Redirect during START: it is latched into pc and START still proceeds to FETCH.
- Simultaneous redirect and transfer: the transfer completes on the decode side, then the flush applies.
- Throughput is one instruction per cycle with if_ready held at 1. The output register is the only buffering.
- Reset asserted mid-operation: immediate return to reset values regardless of state or handshake.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count [31:0], which increments on every transfer.
  - Adds output stall_count [31:0], which increments on every cycle with if_valid=1 and if_ready=0.
  - Both counters reset to 0, wrap at 2^32, and are unaffected by redirect.
- Not defined: neither port nor any counter logic exists. All other behaviour is identical.

Test Plan:
- Reset then sequential run: memory holds 0x00000013 at 0..3 and if_ready=1 → if_valid rises 2 cycles after reset release; if_pc goes 0,1,2,3 on consecutive cycles; if_instr=0x00000013.
- Stall: drop if_ready for 3 cycles while if_pc=2 → if_pc=2 and imem_addr=3 held for 3 cycles; stall_count=3 when FETCH_PERF_CNT_EN is defined; resumes at if_pc=3.
- Redirect with flush: pulse redirect_valid with target=20 while stalled at if_pc=5 → next cycle if_valid=0, imem_addr=20; following cycle if_pc=20.
- Wrap and clamp: sequential fetch from pc 46 → if_pc 46, 47, 0. Redirect target=50 → imem_addr=0.
- Halt: word 0x00100073 at index 7 → if_pc=7 presented; halted=1; imem_addr stays at 7; after the transfer, if_valid=0. Redirect target=1 → halted=0 and fetch resumes at 1.
- Async reset mid-stall: assert rst between clock edges while if_valid=1 → if_valid=0 and imem_addr=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of a combinational instruction
// memory. Owns the word-index PC, captures the returned word into a registered
// valid/ready output stage, and handles stalls, redirects with flush, and EBREAK halt.
//
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count / stall_count outputs.
//
// state | meaning
// ------+-------------------------------------------------------------
// START | first cycle after reset release; imem_addr settles, no capture
// FETCH | capturing imem_data into the output register whenever it is free
// HALT  | EBREAK captured; pc frozen, no further capture until redirect
module fetch_unit #(
   parameter int              ADDR_W     = 6,
   parameter int              MEM_DEPTH  = 48,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [31:0]     HALT_INSTR = 32'h00100073
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [31:0]       if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic              halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_count,
   output logic [31:0]       stall_count
`endif
);

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              if_valid_q, if_valid_d;
   logic [31:0]       if_instr_q, if_instr_d;
   logic [ADDR_W-1:0] if_pc_q, if_pc_d;

   logic              xfer;
   logic              out_free;
   logic [ADDR_W-1:0] redir_pc;
   logic [ADDR_W-1:0] seq_pc;

   // Handshake decode, clamped redirect destination and wrapping sequential PC
   always_comb begin
      xfer     = if_valid_q & if_ready;
      out_free = ~if_valid_q | if_ready;
      // Out-of-range targets land on word 0 rather than reading past memory.
      redir_pc = (32'(redirect_target) >= 32'(MEM_DEPTH)) ? '0 : redirect_target;
      seq_pc   = (pc_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;
   end

   // Next-state, PC and output-register update; redirect outranks everything
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      unique case (state_q)
         ST_START: begin
            // A redirect here only steers the PC; START always proceeds.
            state_d = ST_FETCH;
            if (redirect_valid) pc_d = redir_pc;
         end
         ST_FETCH: begin
            if (redirect_valid) begin
               pc_d       = redir_pc;
               if_valid_d = 1'b0;
            end else if (out_free) begin
               if_instr_d = imem_data;
               if_pc_d    = pc_q;
               if_valid_d = 1'b1;
               if (imem_data == HALT_INSTR) state_d = ST_HALT;
               else                         pc_d    = seq_pc;
            end
         end
         ST_HALT: begin
            if (redirect_valid) begin
               pc_d       = redir_pc;
               if_valid_d = 1'b0;
               state_d    = ST_FETCH;
            end else if (xfer) begin
               if_valid_d = 1'b0;
            end
         end
         default: begin
            state_d    = ST_START;
            pc_d       = RESET_PC;
            if_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_START;
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_instr_q <= '0;
         if_pc_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
      end
   end

   assign imem_addr = pc_q;
   assign if_valid  = if_valid_q;
   assign if_instr  = if_instr_q;
   assign if_pc     = if_pc_q;
   assign halted    = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] stall_count_q, stall_count_d;

   // Performance counters: transfers and stalled-presentation cycles
   always_comb begin
      fetch_count_d = fetch_count_q;
      stall_count_d = stall_count_q;
      if (xfer)                     fetch_count_d = fetch_count_q + 32'd1;
      if (if_valid_q && !if_ready)  stall_count_d = stall_count_q + 32'd1;
   end

   // Counter registers, untouched by redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         fetch_count_q <= fetch_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a behavioural combinational memory.
module tb_fetch_unit;

   localparam int          ADDR_W = 6;
   localparam int          DEPTH  = 48;
   localparam logic [31:0] NOP    = 32'h00000013;
   localparam logic [31:0] EBRK   = 32'h00100073;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic              redirect_valid = 1'b0;
   logic [ADDR_W-1:0] redirect_target = '0;
   logic              if_valid;
   logic              if_ready = 1'b1;
   logic [31:0]       if_instr;
   logic [ADDR_W-1:0] if_pc;
   logic              halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]       fetch_count;
   logic [31:0]       stall_count;
`endif

   logic [31:0] mem [0:DEPTH-1];
   int n_vec = 0;
   int n_err = 0;

   assign imem_data = (int'(imem_addr) < DEPTH) ? mem[imem_addr] : 32'hDEAD_BEEF;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .halted          (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count     (fetch_count),
      .stall_count     (stall_count)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", if_valid); end
      n_vec++; if (imem_addr !== 6'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
      n_vec++; if (if_instr !== 32'd0) begin n_err++; $display("FAIL reset_instr got %h want 0", if_instr); end
      n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %0b want 0", halted); end
      rst = 1'b0;
      tick();
      n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL start_no_capture got %0b want 0", if_valid); end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (if_valid !== 1'b1 || if_pc !== 6'(i) || if_instr !== NOP) begin
            n_err++; $display("FAIL seq_%0d got v=%0b pc=%0d instr=%h want v=1 pc=%0d instr=%h", i, if_valid, if_pc, if_instr, i, NOP);
         end
      end
   endtask

   task automatic test_stall();
      if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (if_valid !== 1'b1 || if_pc !== 6'd2 || imem_addr !== 6'd3) begin
            n_err++; $display("FAIL stall_%0d got v=%0b pc=%0d addr=%0d want v=1 pc=2 addr=3", i, if_valid, if_pc, imem_addr);
         end
      end
`ifdef FETCH_PERF_CNT_EN
      n_vec++; if (stall_count !== 32'd3) begin n_err++; $display("FAIL stall_count got %0d want 3", stall_count); end
`endif
      if_ready = 1'b1;
      for (int i = 3; i < 6; i++) begin
         tick();
         n_vec++; if (if_valid !== 1'b1 || if_pc !== 6'(i)) begin
            n_err++; $display("FAIL resume_%0d got v=%0b pc=%0d want v=1 pc=%0d", i, if_valid, if_pc, i);
         end
      end
   endtask

   task automatic test_redirect();
      if_ready = 1'b0;
      tick();
      redirect_valid  = 1'b1;
      redirect_target = 6'd20;
      tick();
      redirect_valid = 1'b0;
      n_vec++; if (if_valid !== 1'b0 || imem_addr !== 6'd20) begin
         n_err++; $display("FAIL redir_flush got v=%0b addr=%0d want v=0 addr=20", if_valid, imem_addr);
      end
      if_ready = 1'b1;
      tick();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== 6'd20) begin
         n_err++; $display("FAIL redir_target got v=%0b pc=%0d want v=1 pc=20", if_valid, if_pc);
      end
`ifdef FETCH_PERF_CNT_EN
      n_vec++; if (fetch_count !== 32'd5 || stall_count !== 32'd5) begin
         n_err++; $display("FAIL perf_counts got f=%0d s=%0d want f=5 s=5", fetch_count, stall_count);
      end
`endif
   endtask

   task automatic test_wrap_clamp();
      logic [ADDR_W-1:0] exp_pc [3];
      exp_pc[0] = 6'd46; exp_pc[1] = 6'd47; exp_pc[2] = 6'd0;
      redirect_valid  = 1'b1;
      redirect_target = 6'd46;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (if_valid !== 1'b1 || if_pc !== exp_pc[i]) begin
            n_err++; $display("FAIL wrap_%0d got v=%0b pc=%0d want v=1 pc=%0d", i, if_valid, if_pc, exp_pc[i]);
         end
      end
      redirect_valid  = 1'b1;
      redirect_target = 6'd50;
      tick();
      redirect_valid = 1'b0;
      n_vec++; if (imem_addr !== 6'd0 || if_valid !== 1'b0) begin
         n_err++; $display("FAIL clamp got addr=%0d v=%0b want addr=0 v=0", imem_addr, if_valid);
      end
   endtask

   task automatic test_halt();
      redirect_valid  = 1'b1;
      redirect_target = 6'd5;
      tick();
      redirect_valid = 1'b0;
      repeat (2) tick();
      tick();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== 6'd7 || if_instr !== EBRK || halted !== 1'b1 || imem_addr !== 6'd7) begin
         n_err++; $display("FAIL halt_enter got v=%0b pc=%0d instr=%h h=%0b addr=%0d want v=1 pc=7 instr=%h h=1 addr=7", if_valid, if_pc, if_instr, halted, imem_addr, EBRK);
      end
      if_ready = 1'b0;
      tick();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== 6'd7 || imem_addr !== 6'd7) begin
         n_err++; $display("FAIL halt_hold got v=%0b pc=%0d addr=%0d want v=1 pc=7 addr=7", if_valid, if_pc, imem_addr);
      end
      if_ready = 1'b1;
      repeat (2) begin
         tick();
         n_vec++; if (if_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 6'd7) begin
            n_err++; $display("FAIL halt_drained got v=%0b h=%0b addr=%0d want v=0 h=1 addr=7", if_valid, halted, imem_addr);
         end
      end
      redirect_valid  = 1'b1;
      redirect_target = 6'd1;
      tick();
      redirect_valid = 1'b0;
      n_vec++; if (halted !== 1'b0 || imem_addr !== 6'd1) begin
         n_err++; $display("FAIL halt_exit got h=%0b addr=%0d want h=0 addr=1", halted, imem_addr);
      end
      tick();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== 6'd1) begin
         n_err++; $display("FAIL halt_resume got v=%0b pc=%0d want v=1 pc=1", if_valid, if_pc);
      end
   endtask

   task automatic test_async_reset();
      if_ready = 1'b0;
      tick();
      #3;
      rst = 1'b1;
      #1;
      n_vec++; if (if_valid !== 1'b0 || imem_addr !== 6'd0 || if_pc !== 6'd0) begin
         n_err++; $display("FAIL async_reset got v=%0b addr=%0d pc=%0d want v=0 addr=0 pc=0", if_valid, imem_addr, if_pc);
      end
`ifdef FETCH_PERF_CNT_EN
      n_vec++; if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
         n_err++; $display("FAIL async_reset_cnt got f=%0d s=%0d want 0 0", fetch_count, stall_count);
      end
`endif
      tick();
      rst = 1'b0;
      if_ready = 1'b1;
      repeat (2) tick();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== 6'd0) begin
         n_err++; $display("FAIL post_reset got v=%0b pc=%0d want v=1 pc=0", if_valid, if_pc);
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = NOP;
      mem[7] = EBRK;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_wrap_clamp();
      test_halt();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
